// File: rtl/me_pkg.sv
// Shared types and geometry constants for the motion-estimation frame loader.
package me_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_R,
    ST_LOAD_S,
    ST_RUN,
    ST_SETTLE,
    ST_DONE
  } me_state_t;

  localparam int ME_R_PIXELS    = 256;
  localparam int ME_S_PIXELS    = 1024;
  localparam int ME_RUN_CYCLES  = 4112;
  localparam int ME_BLK         = 16;
  localparam int ME_WIN         = 32;
  localparam int ME_RUN_TIMEOUT = 4200;

endpackage

// File: rtl/me_pixel_buffer.sv
// Pixel store: one synchronous write port, two asynchronous read ports.
import me_pkg::*;

module me_pixel_buffer #(
  parameter int DW    = 8,
  parameter int DEPTH = ME_R_PIXELS,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/me_frame_loader.sv
// Streams reference block and search window into local buffers, then
// runs the ME engine against them and latches its best match.
import me_pkg::*;

module me_frame_loader #(
  parameter int DW          = 8,
  parameter int R_DEPTH     = ME_R_PIXELS,
  parameter int S_DEPTH     = ME_S_PIXELS,
  parameter int RUN_TIMEOUT = ME_RUN_TIMEOUT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_req,
  input  logic          pix_valid,
  input  logic [DW-1:0] pix_data,
  output logic          pix_ready,
  output logic          me_start,
  input  logic          me_completed,
  input  logic [7:0]    AddressR,
  input  logic [9:0]    AddressS1,
  input  logic [9:0]    AddressS2,
  output logic [DW-1:0] R,
  output logic [DW-1:0] S1,
  output logic [DW-1:0] S2,
  input  logic [7:0]    BestDist_in,
  input  logic [3:0]    motionX_in,
  input  logic [3:0]    motionY_in,
  output logic          busy,
  output logic          result_valid,
  output logic [7:0]    result_dist,
  output logic [3:0]    result_mx,
  output logic [3:0]    result_my,
  output logic          timeout_err
);

  me_state_t state, state_nx;

  logic [9:0]    wr_cnt;
  logic [12:0]   run_cnt;
  logic          wr_fire;
  logic          r_we;
  logic          s_we;
  logic          r_last;
  logic          s_last;
  logic          run_expire;
  logic [DW-1:0] r_unused;

  assign pix_ready    = (state == ST_LOAD_R) || (state == ST_LOAD_S);
  assign me_start     = (state == ST_RUN) || (state == ST_SETTLE);
  assign busy         = (state != ST_IDLE);
  assign result_valid = (state == ST_DONE);

  assign wr_fire    = pix_valid && pix_ready;
  assign r_we       = wr_fire && (state == ST_LOAD_R);
  assign s_we       = wr_fire && (state == ST_LOAD_S);
  assign r_last     = (wr_cnt == 10'(R_DEPTH - 1));
  assign s_last     = (wr_cnt == 10'(S_DEPTH - 1));
  assign run_expire = (run_cnt == 13'(RUN_TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (load_req) state_nx = ST_LOAD_R;
      ST_LOAD_R: if (r_we && r_last) state_nx = ST_LOAD_S;
      ST_LOAD_S: if (s_we && s_last) state_nx = ST_RUN;
      ST_RUN: begin
        if (me_completed)    state_nx = ST_SETTLE;
        else if (run_expire) state_nx = ST_IDLE;
      end
      ST_SETTLE: state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_IDLE;
      wr_cnt      <= '0;
      run_cnt     <= '0;
      timeout_err <= 1'b0;
      result_dist <= '0;
      result_mx   <= '0;
      result_my   <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && load_req) begin
        wr_cnt      <= '0;
        timeout_err <= 1'b0;
      end else if (wr_fire) begin
        if ((r_we && r_last) || (s_we && s_last)) wr_cnt <= '0;
        else wr_cnt <= wr_cnt + 10'd1;
      end
      run_cnt <= (state == ST_RUN) ? run_cnt + 13'd1 : '0;
      if (state == ST_RUN && !me_completed && run_expire)
        timeout_err <= 1'b1;
      // engine's last comparator update is visible only in SETTLE
      if (state == ST_SETTLE) begin
        result_dist <= BestDist_in;
        result_mx   <= motionX_in;
        result_my   <= motionY_in;
      end
    end
  end

  me_pixel_buffer #(.DW(DW), .DEPTH(R_DEPTH)) u_rbuf (
    .clock   (clock),
    .we      (r_we),
    .waddr   (wr_cnt[7:0]),
    .wdata   (pix_data),
    .raddr_a (AddressR),
    .raddr_b (8'd0),
    .rdata_a (R),
    .rdata_b (r_unused)
  );

  me_pixel_buffer #(.DW(DW), .DEPTH(S_DEPTH)) u_sbuf (
    .clock   (clock),
    .we      (s_we),
    .waddr   (wr_cnt),
    .wdata   (pix_data),
    .raddr_a (AddressS1),
    .raddr_b (AddressS2),
    .rdata_a (S1),
    .rdata_b (S2)
  );

endmodule

// File: tb/tb_me_frame_loader.sv
// Scoreboard bench for me_frame_loader with a small behavioural ME engine.
module tb_me_frame_loader;

  logic       clock = 1'b0;
  logic       reset;
  logic       load_req;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       pix_ready;
  logic       me_start;
  logic       me_completed;
  logic [7:0] AddressR;
  logic [9:0] AddressS1;
  logic [9:0] AddressS2;
  logic [7:0] R;
  logic [7:0] S1;
  logic [7:0] S2;
  logic [7:0] BestDist_in = 8'hFF;
  logic [3:0] motionX_in  = 4'hF;
  logic [3:0] motionY_in  = 4'hF;
  logic       busy;
  logic       result_valid;
  logic [7:0] result_dist;
  logic [3:0] result_mx;
  logic [3:0] result_my;
  logic       timeout_err;

  always #5 clock = ~clock;

  me_frame_loader dut (
    .clock        (clock),
    .reset        (reset),
    .load_req     (load_req),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_ready    (pix_ready),
    .me_start     (me_start),
    .me_completed (me_completed),
    .AddressR     (AddressR),
    .AddressS1    (AddressS1),
    .AddressS2    (AddressS2),
    .R            (R),
    .S1           (S1),
    .S2           (S2),
    .BestDist_in  (BestDist_in),
    .motionX_in   (motionX_in),
    .motionY_in   (motionY_in),
    .busy         (busy),
    .result_valid (result_valid),
    .result_dist  (result_dist),
    .result_mx    (result_mx),
    .result_my    (result_my),
    .timeout_err  (timeout_err)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] rdat [256];
  logic [7:0] sdat [1024];

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] x;
    logic [3:0] y;
  } res_t;
  res_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // behavioural engine: SAD at (3,5) on port S1 vs (0,0) on port S2
  logic       eng_en = 1'b0;
  int         ecnt = 0;
  int         sad1 = 0;
  int         sad2 = 0;
  logic [7:0] tb_ar = '0;
  logic [9:0] tb_as1 = '0;
  logic [9:0] tb_as2 = '0;
  logic [7:0] eng_ar;
  logic [9:0] eng_as1;
  logic [9:0] eng_as2;

  function automatic int absd(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? int'(a) - int'(b) : int'(b) - int'(a);
  endfunction

  function automatic logic [7:0] sat8(input int v);
    return (v > 255) ? 8'hFF : 8'(v);
  endfunction

  always_comb begin
    eng_ar  = 8'(ecnt % 256);
    eng_as1 = 10'((5 + (ecnt % 256) / 16) * 32 + 3 + ecnt % 16);
    eng_as2 = 10'(((ecnt % 256) / 16) * 32 + ecnt % 16);
  end

  assign AddressR     = eng_en ? eng_ar : tb_ar;
  assign AddressS1    = eng_en ? eng_as1 : tb_as1;
  assign AddressS2    = eng_en ? eng_as2 : tb_as2;
  assign me_completed = eng_en && me_start && (ecnt >= 4111);

  always @(posedge clock) begin
    if (me_start !== 1'b1) begin
      ecnt <= 0;
      sad1 <= 0;
      sad2 <= 0;
    end else begin
      ecnt <= ecnt + 1;
      if (ecnt < 256) begin
        sad1 <= sad1 + absd(R, S1);
        sad2 <= sad2 + absd(R, S2);
      end
    end
  end

  always @(posedge clock) begin
    if (me_start !== 1'b1) begin
      BestDist_in <= 8'hFF;
      motionX_in  <= 4'hF;
      motionY_in  <= 4'hF;
    end else if (me_completed) begin
      if (sad1 <= sad2) begin
        BestDist_in <= sat8(sad1);
        motionX_in  <= 4'd3;
        motionY_in  <= 4'd5;
      end else begin
        BestDist_in <= sat8(sad2);
        motionX_in  <= 4'd0;
        motionY_in  <= 4'd0;
      end
    end
  end

  // monitor: every result pulse must match the oldest expectation
  always @(negedge clock) begin
    res_t e;
    if (reset === 1'b1 && result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got dist=%0h want no pulse",
                 result_dist);
      end else begin
        e = exp_q.pop_front();
        chk("result_dist", 32'(result_dist), 32'(e.d));
        chk("result_mx", 32'(result_mx), 32'(e.x));
        chk("result_my", 32'(result_my), 32'(e.y));
      end
    end
  end

  task automatic rd_r(input string nm, input logic [7:0] a,
                      input logic [7:0] want);
    tb_ar = a;
    #1;
    chk(nm, 32'(R), 32'(want));
  endtask

  task automatic rd_s1(input string nm, input logic [9:0] a,
                       input logic [7:0] want);
    tb_as1 = a;
    #1;
    chk(nm, 32'(S1), 32'(want));
  endtask

  task automatic rd_s2(input string nm, input logic [9:0] a,
                       input logic [7:0] want);
    tb_as2 = a;
    #1;
    chk(nm, 32'(S2), 32'(want));
  endtask

  // issue load_req, stream R then S; returns edges until me_start and bytes sent
  task automatic stream(input bit toggle, output int edges, output int acc);
    int n = 0;
    int idx = 0;
    @(negedge clock);
    load_req = 1'b1;
    @(negedge clock);
    load_req = 1'b0;
    while (me_start !== 1'b1 && n < 4000) begin
      if (pix_ready === 1'b1 && (!toggle || (n % 2) == 0)) begin
        pix_valid = 1'b1;
        if (idx < 256)       pix_data = rdat[idx];
        else if (idx < 1280) pix_data = sdat[idx-256];
        else                 pix_data = 8'hEE;
        idx++;
      end else begin
        pix_valid = 1'b0;
      end
      @(negedge clock);
      n++;
    end
    pix_valid = 1'b0;
    edges = n;
    acc = idx;
  endtask

  initial begin
    int e;
    int a;
    int m;
    int c;
    reset     = 1'b0;
    load_req  = 1'b0;
    pix_valid = 1'b0;
    pix_data  = '0;

    // reset state
    repeat (2) @(negedge clock);
    chk("rst_me_start", 32'(me_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_result_valid", 32'(result_valid), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    chk("rst_pix_ready", 32'(pix_ready), 0);
    chk("rst_result_dist", 32'(result_dist), 0);
    reset = 1'b1;
    @(negedge clock);
    chk("idle_busy", 32'(busy), 0);

    // ordered load, continuous valid
    for (int i = 0; i < 256; i++) rdat[i] = 8'(i);
    for (int i = 0; i < 1024; i++) sdat[i] = 8'((i * 7) & 255);
    stream(1'b0, e, a);
    chk("load_edges", 32'(e), 1280);
    chk("load_bytes", 32'(a), 1280);
    chk("run_pix_ready", 32'(pix_ready), 0);
    rd_r("R_5A", 8'h5A, 8'h5A);
    rd_s1("S1_3FF", 10'h3FF, 8'hF9);
    rd_s2("S2_001", 10'h001, 8'h07);

    // engine never completes: timeout
    m = 0;
    while (me_start === 1'b1 && m < 5000) begin
      @(negedge clock);
      m++;
    end
    chk("timeout_cycles", 32'(m), 4200);
    chk("timeout_err_set", 32'(timeout_err), 1);
    chk("timeout_busy", 32'(busy), 0);
    @(negedge clock);
    chk("timeout_err_sticky", 32'(timeout_err), 1);

    // backpressure load; also clears timeout_err
    for (int i = 0; i < 256; i++) rdat[i] = 8'(255 - i);
    for (int i = 0; i < 1024; i++) sdat[i] = 8'((i * 3 + 1) & 255);
    stream(1'b1, e, a);
    chk("bp_bytes", 32'(a), 1280);
    chk("bp_timeout_clr", 32'(timeout_err), 0);
    rd_r("bp_R_10", 8'h10, 8'hEF);
    rd_s2("bp_S2_3FF", 10'h3FF, 8'hFE);
    pix_valid = 1'b1;
    pix_data  = 8'hAA;
    repeat (4) begin
      @(negedge clock);
      chk("bp_run_ready", 32'(pix_ready), 0);
    end
    pix_valid = 1'b0;
    rd_s1("bp_S1_000", 10'h000, 8'h01);

    // reset at RUN cycle 2000
    repeat (2000 - 4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_me_start", 32'(me_start), 0);
    chk("midrst_busy", 32'(busy), 0);
    reset = 1'b1;

    // full run: R copied from S at offset (3,5)
    for (int i = 0; i < 1024; i++) sdat[i] = 8'((i * 13 + 5) & 255);
    for (int k = 0; k < 256; k++)
      rdat[k] = sdat[(5 + k / 16) * 32 + 3 + k % 16];
    exp_q.push_back('{d: 8'h00, x: 4'd3, y: 4'd5});
    stream(1'b0, e, a);
    chk("run_load_edges", 32'(e), 1280);
    rd_r("run_R_00", 8'h00, 8'h4C);
    rd_s1("run_S1_3FF", 10'h3FF, 8'hF8);
    eng_en = 1'b1;
    c = 0;
    while (result_valid !== 1'b1 && c < 5000) begin
      @(negedge clock);
      c++;
    end
    chk("run_to_result", 32'(c + 1), 4114);
    @(negedge clock);
    chk("result_one_pulse", 32'(result_valid), 0);
    chk("done_busy", 32'(busy), 0);
    chk("done_me_start", 32'(me_start), 0);
    chk("result_held", 32'(result_dist), 0);
    eng_en = 1'b0;

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
